lzma2_perf_monitor: RTL and testbench

LZMA2_PERF_MONITOR -- requirements
Module: lzma2_perf_monitor

---
 rtl/lzma2_perf_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_lzma2_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzma2_perf_monitor.sv
// lzma2_perf_monitor: run-time performance monitor for the LZMA2 datapath.
// Counts cycles, stall cycles and NUM_EVT event streams while a run is active,
// copies them into readable snapshot registers every INTERVAL cycles and at
// the end of a run, and traps stall / no-progress / protocol errors.
// Optional feature: define LZMA2_PERF_UTIL_EN to enable per-interval
// utilisation counting on util_cnt (otherwise util_cnt is tied to zero).
module lzma2_perf_monitor #(
   parameter int NUM_EVT        = 8,
   parameter int CNT_W          = 32,
   parameter int INTERVAL       = 1000,
   parameter int STALL_LIMIT    = 1000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         done,
   input  logic                         clear,
   input  logic [NUM_EVT-1:0]           evt,
   input  logic                         stall,
   input  logic                         progress,
   input  logic [$clog2(NUM_EVT+2)-1:0] rd_sel,
   output logic [CNT_W-1:0]             rd_data,
   output logic                         busy,
   output logic                         snap_valid,
   output logic                         sat_warn,
   output logic [3:0]                   err_code,
   output logic [CNT_W-1:0]             util_cnt
);

   localparam int SEL_W = $clog2(NUM_EVT+2);
   localparam int INT_W = $clog2(INTERVAL+1);
   localparam int STL_W = $clog2(STALL_LIMIT+1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);

   localparam logic [INT_W-1:0] INT_LAST = INT_W'(INTERVAL-1);
   localparam logic [STL_W-1:0] STL_LAST = STL_W'(STALL_LIMIT-1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);
   localparam logic [SEL_W-1:0] SEL_CYC  = SEL_W'(NUM_EVT);
   localparam logic [SEL_W-1:0] SEL_STL  = SEL_W'(NUM_EVT+1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD, ERROR} state_t;

   state_t           state, state_nxt;
   logic [3:0]       err_nxt;

   logic [CNT_W-1:0] evt_cnt  [NUM_EVT];
   logic [CNT_W-1:0] evt_nxt  [NUM_EVT];
   logic [CNT_W-1:0] evt_snap [NUM_EVT];
   logic [CNT_W-1:0] cyc_cnt, cyc_nxt, cyc_snap;
   logic [CNT_W-1:0] stl_cnt, stl_nxt, stl_snap;
   logic [INT_W-1:0] int_cnt;
   logic [STL_W-1:0] stl_run;
   logic [TMO_W-1:0] np_cnt;
   logic [CNT_W-1:0] rd_mux;

   logic launch;     // new run begins: live and watchdog counters restart
   logic wipe;       // clear accepted: snapshots, live counters, sat_warn zeroed
   logic take_snap;  // copy live counters into snapshots this edge
   logic wrap;
   logic sat_hit;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   // True when this increment lands on (or pushes against) the ceiling.
   function automatic logic sat_reach(input logic [CNT_W-1:0] v, input logic en);
      return en && (v >= CNT_MAX - CNT_W'(1));
   endfunction

   assign busy = (state == RUN);
   assign wrap = (int_cnt == INT_LAST);

   // Next-state and error decode; errors outrank done, done outranks the interval wrap.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_code;
      launch    = 1'b0;
      wipe      = 1'b0;
      take_snap = 1'b0;
      case (state)
         IDLE, HOLD: begin
            if (clear) wipe = 1'b1;
            if (start) begin
               launch    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (start) begin
               state_nxt = ERROR;
               err_nxt   = 4'h5;
            end else if (stall && (stl_run == STL_LAST)) begin
               state_nxt = ERROR;
               err_nxt   = 4'h6;
            end else if (!progress && (np_cnt == TMO_LAST)) begin
               state_nxt = ERROR;
               err_nxt   = 4'h4;
            end else if (done) begin
               state_nxt = HOLD;
               take_snap = 1'b1;
            end else if (wrap) begin
               take_snap = 1'b1;
            end
         end
         ERROR: begin
            if (clear) begin
               state_nxt = IDLE;
               err_nxt   = 4'h0;
               wipe      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Candidate live-counter values including this cycle's increments.
   always_comb begin
      cyc_nxt = sat_inc(cyc_cnt, 1'b1);
      stl_nxt = sat_inc(stl_cnt, stall);
      sat_hit = sat_reach(cyc_cnt, 1'b1) | sat_reach(stl_cnt, stall);
      for (int i = 0; i < NUM_EVT; i++) begin
         evt_nxt[i] = sat_inc(evt_cnt[i], evt[i]);
         sat_hit    = sat_hit | sat_reach(evt_cnt[i], evt[i]);
      end
   end

   // State, error code and sticky saturation warning.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         err_code <= 4'h0;
         sat_warn <= 1'b0;
      end else begin
         state    <= state_nxt;
         err_code <= err_nxt;
         if (launch || wipe)
            sat_warn <= 1'b0;
         else if ((state == RUN) && sat_hit)
            sat_warn <= 1'b1;
      end
   end

   // Live counters and watchdogs advance only in RUN; frozen elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_EVT; i++) evt_cnt[i] <= '0;
         cyc_cnt <= '0;
         stl_cnt <= '0;
         int_cnt <= '0;
         stl_run <= '0;
         np_cnt  <= '0;
      end else if (launch || wipe) begin
         for (int i = 0; i < NUM_EVT; i++) evt_cnt[i] <= '0;
         cyc_cnt <= '0;
         stl_cnt <= '0;
         int_cnt <= '0;
         stl_run <= '0;
         np_cnt  <= '0;
      end else if (state == RUN) begin
         for (int i = 0; i < NUM_EVT; i++) evt_cnt[i] <= evt_nxt[i];
         cyc_cnt <= cyc_nxt;
         stl_cnt <= stl_nxt;
         int_cnt <= wrap ? '0 : int_cnt + INT_W'(1);
         stl_run <= stall ? stl_run + STL_W'(1) : '0;
         np_cnt  <= progress ? '0 : np_cnt + TMO_W'(1);
      end
   end

   // Snapshot capture uses the post-increment values so the snapshot-cycle events are included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_EVT; i++) evt_snap[i] <= '0;
         cyc_snap   <= '0;
         stl_snap   <= '0;
         snap_valid <= 1'b0;
      end else begin
         snap_valid <= take_snap;
         if (wipe) begin
            for (int i = 0; i < NUM_EVT; i++) evt_snap[i] <= '0;
            cyc_snap <= '0;
            stl_snap <= '0;
         end else if (take_snap) begin
            for (int i = 0; i < NUM_EVT; i++) evt_snap[i] <= evt_nxt[i];
            cyc_snap <= cyc_nxt;
            stl_snap <= stl_nxt;
         end
      end
   end

   // Read-select decode; out-of-range selects read zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_EVT; i++)
         if (rd_sel == SEL_W'(i)) rd_mux = evt_snap[i];
      if (rd_sel == SEL_CYC) rd_mux = cyc_snap;
      if (rd_sel == SEL_STL) rd_mux = stl_snap;
   end

   // Registered read port, one cycle behind rd_sel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= rd_mux;
   end

`ifdef LZMA2_PERF_UTIL_EN
   logic [CNT_W-1:0] util_run;

   // Non-stall cycles in the current interval, published on each snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         util_run <= '0;
         util_cnt <= '0;
      end else if (launch || wipe) begin
         util_run <= '0;
         if (wipe) util_cnt <= '0;
      end else if (state == RUN) begin
         if (take_snap) begin
            util_cnt <= sat_inc(util_run, !stall);
            util_run <= '0;
         end else begin
            util_run <= sat_inc(util_run, !stall);
         end
      end
   end
`else
   assign util_cnt = '0;
`endif

endmodule

// File: tb/tb_lzma2_perf_monitor.sv
// Directed bench for lzma2_perf_monitor: two instances, one with short
// interval/stall/timeout limits and one with 4-bit counters for saturation.
module tb_lzma2_perf_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

`ifdef LZMA2_PERF_UTIL_EN
   localparam logic [31:0] UTIL_A_EXP = 32'd7;
   localparam logic [31:0] UTIL_B_EXP = 32'd15;
`else
   localparam logic [31:0] UTIL_A_EXP = 32'd0;
   localparam logic [31:0] UTIL_B_EXP = 32'd0;
`endif

   // Instance A: NUM_EVT=8, CNT_W=32, INTERVAL=10, STALL_LIMIT=5, TIMEOUT=16
   logic        a_start = 0, a_done = 0, a_clear = 0, a_stall = 0, a_progress = 1;
   logic [7:0]  a_evt = '0;
   logic [3:0]  a_rd_sel = '0;
   logic [31:0] a_rd_data, a_util;
   logic        a_busy, a_snap_valid, a_sat_warn;
   logic [3:0]  a_err;

   lzma2_perf_monitor #(
      .NUM_EVT(8), .CNT_W(32), .INTERVAL(10), .STALL_LIMIT(5), .TIMEOUT_CYCLES(16)
   ) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .done(a_done), .clear(a_clear),
      .evt(a_evt), .stall(a_stall), .progress(a_progress), .rd_sel(a_rd_sel),
      .rd_data(a_rd_data), .busy(a_busy), .snap_valid(a_snap_valid),
      .sat_warn(a_sat_warn), .err_code(a_err), .util_cnt(a_util)
   );

   // Instance B: CNT_W=4 for saturation behaviour
   logic        b_start = 0, b_done = 0, b_clear = 0, b_stall = 0, b_progress = 1;
   logic [7:0]  b_evt = '0;
   logic [3:0]  b_rd_sel = '0;
   logic [3:0]  b_rd_data, b_util;
   logic        b_busy, b_snap_valid, b_sat_warn;
   logic [3:0]  b_err;

   lzma2_perf_monitor #(
      .NUM_EVT(8), .CNT_W(4)
   ) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .done(b_done), .clear(b_clear),
      .evt(b_evt), .stall(b_stall), .progress(b_progress), .rd_sel(b_rd_sel),
      .rd_data(b_rd_data), .busy(b_busy), .snap_valid(b_snap_valid),
      .sat_warn(b_sat_warn), .err_code(b_err), .util_cnt(b_util)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // ---- asynchronous reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", a_busy, 0);
      chk("rst_snap_valid", a_snap_valid, 0);
      chk("rst_sat_warn", a_sat_warn, 0);
      chk("rst_err", a_err, 0);
      chk("rst_rd_data", a_rd_data, 0);
      chk("rst_util", a_util, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // ---- periodic snapshots every 10 cycles, evt[0] every cycle
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_evt   = 8'h01;
      chk("run_busy", a_busy, 1);
      for (int k = 1; k <= 25; k++) begin
         tick();
         chk($sformatf("snap_valid_c%0d", k), a_snap_valid, (k == 10 || k == 20));
         if (k == 11) chk("rd_evt0_first", a_rd_data, 10);
         if (k == 21) chk("rd_evt0_second", a_rd_data, 20);
      end
      a_evt    = 8'h00;
      a_rd_sel = 4'd8;
      tick();                                  // cycle 26
      chk("rd_cyc_snap", a_rd_data, 20);
      a_rd_sel = 4'd9;
      tick();                                  // cycle 27
      chk("rd_stall_snap", a_rd_data, 0);
      a_rd_sel = 4'd1;
      tick();                                  // cycle 28
      chk("rd_evt1_snap", a_rd_data, 0);
      a_rd_sel = 4'd15;
      tick();                                  // cycle 29
      chk("rd_out_of_range", a_rd_data, 0);

      // ---- done coinciding with interval wrap (cycle 30)
      a_done = 1'b1;
      tick();
      a_done = 1'b0;
      chk("done_wrap_pulse", a_snap_valid, 1);
      chk("done_hold_busy", a_busy, 0);
      a_rd_sel = 4'd8;
      tick();
      chk("done_single_pulse", a_snap_valid, 0);
      chk("final_cyc_snap", a_rd_data, 30);
      a_rd_sel = 4'd0;
      tick();
      chk("final_evt0_snap", a_rd_data, 25);

      // ---- clear in HOLD zeroes snapshots
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      tick();
      chk("hold_clear_snap", a_rd_data, 0);

      // ---- utilisation and stall snapshot: stall on cycles 2..4 of a 10-cycle interval
      a_start = 1'b1;
      tick();
      a_start  = 1'b0;
      a_rd_sel = 4'd9;
      for (int k = 1; k <= 10; k++) begin
         a_stall = (k >= 2 && k <= 4);
         tick();
      end
      chk("util_snap_valid", a_snap_valid, 1);
      chk("util_cnt", a_util, UTIL_A_EXP);
      a_stall = 1'b0;
      tick();
      chk("rd_stall_cnt", a_rd_data, 3);

      // ---- five consecutive stall cycles trap with code 6
      a_stall = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         tick();
         chk($sformatf("stall_busy_%0d", j), a_busy, (j < 5));
         chk($sformatf("stall_err_%0d", j), a_err, (j == 5) ? 4'h6 : 4'h0);
      end
      a_stall = 1'b0;
      tick();
      chk("error_held", a_err, 4'h6);
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      chk("clear_err", a_err, 0);
      chk("clear_busy", a_busy, 0);
      tick();
      chk("clear_snap_zero", a_rd_data, 0);

      // ---- 16 cycles without progress trap with code 4
      a_start = 1'b1;
      tick();
      a_start    = 1'b0;
      a_progress = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         tick();
         chk($sformatf("tmo_err_%0d", j), a_err, (j == 16) ? 4'h4 : 4'h0);
      end
      a_progress = 1'b1;
      a_clear    = 1'b1;
      tick();
      a_clear = 1'b0;
      chk("tmo_clear", a_err, 0);

      // ---- stall limit and timeout on the same cycle: stall wins
      a_start = 1'b1;
      tick();
      a_start    = 1'b0;
      a_progress = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         a_stall = (j >= 12);
         tick();
      end
      chk("prio_stall_over_tmo", a_err, 4'h6);
      a_stall    = 1'b0;
      a_progress = 1'b1;
      a_clear    = 1'b1;
      tick();
      a_clear = 1'b0;

      // ---- start while running (with done) traps with code 5
      a_start = 1'b1;
      tick();
      a_done = 1'b1;
      tick();
      a_start = 1'b0;
      a_done  = 1'b0;
      chk("start_in_run_err", a_err, 4'h5);
      chk("start_in_run_no_snap", a_snap_valid, 0);
      chk("start_in_run_busy", a_busy, 0);
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;

      // ---- asynchronous reset in the middle of a run
      a_start = 1'b1;
      tick();
      a_start  = 1'b0;
      a_evt    = 8'hFF;
      a_rd_sel = 4'd0;
      for (int k = 1; k <= 20; k++) tick();
      chk("pre_rst_snap_valid", a_snap_valid, 1);
      chk("pre_rst_rd_data", a_rd_data, 10);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", a_busy, 0);
      chk("async_rst_snap_valid", a_snap_valid, 0);
      chk("async_rst_rd_data", a_rd_data, 0);
      chk("async_rst_err", a_err, 0);
      #1 rst = 1'b0;
      a_evt = 8'h00;
      tick();
      chk("post_rst_no_pulse", a_snap_valid, 0);
      chk("post_rst_idle", a_busy, 0);
      tick();
      chk("post_rst_snap_gone", a_rd_data, 0);

      // ---- 4-bit counters saturate at 15, sat_warn sticky until clear
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_evt   = 8'h08;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk($sformatf("sat_warn_c%0d", k), b_sat_warn, (k >= 15));
      end
      b_evt  = 8'h00;
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
      chk("b_done_pulse", b_snap_valid, 1);
      chk("b_err", b_err, 0);
      chk("b_busy", b_busy, 0);
      chk("b_util", b_util, UTIL_B_EXP);
      b_rd_sel = 4'd3;
      tick();
      chk("sat_evt3", b_rd_data, 15);
      b_rd_sel = 4'd8;
      tick();
      chk("sat_cyc", b_rd_data, 15);
      chk("sat_warn_held", b_sat_warn, 1);
      b_clear  = 1'b1;
      b_rd_sel = 4'd3;
      tick();
      b_clear = 1'b0;
      chk("sat_warn_cleared", b_sat_warn, 0);
      tick();
      chk("sat_snap_cleared", b_rd_data, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
